// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multi-cycle sequencer for an RV32I-subset datapath.
// Sequence: FETCH -> DECODE -> EXEC -> [MEM] -> [WB] -> FETCH, HALT on trap.
// Owns the PC. Decoded fields are captured with the instruction and held
// until the next fetch.
// Optional build macro PERF_CNT_EN adds retired_cnt / stall_cnt outputs.

module multicycle_ctrl #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  output logic        instr_req,
  input  logic        instr_valid,
  input  logic [31:0] instr,
  output logic [31:0] pc_out,
  input  logic        zero_flag,
  input  logic        lt_flag,
  input  logic        mem_ready,
  output logic [4:0]  read_reg_num1,
  output logic [4:0]  read_reg_num2,
  output logic [4:0]  write_reg_num1,
  output logic        reg_write,
  output logic [5:0]  alu_control,
  output logic [31:0] imm_val,
  output logic [4:0]  shamt,
  output logic        lb,
  output logic        sw,
  output logic        lui_control,
  output logic        jump,
  output logic        trap
`ifdef PERF_CNT_EN
  ,
  output logic [31:0] retired_cnt,
  output logic [31:0] stall_cnt
`endif
);

  // FSM states
  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;

  // Opcodes
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  // ALU operation codes
  localparam logic [5:0] ALU_ADD = 6'd0;
  localparam logic [5:0] ALU_SUB = 6'd1;
  localparam logic [5:0] ALU_AND = 6'd2;
  localparam logic [5:0] ALU_OR  = 6'd3;
  localparam logic [5:0] ALU_XOR = 6'd4;
  localparam logic [5:0] ALU_SLL = 6'd5;
  localparam logic [5:0] ALU_SRL = 6'd6;
  localparam logic [5:0] ALU_SRA = 6'd7;
  localparam logic [5:0] ALU_SLT = 6'd8;

  localparam logic [3:0] TMO_LAST = 4'(MEM_TIMEOUT - 1);

  typedef enum logic [2:0] {
    CL_ALU,
    CL_LOAD,
    CL_STORE,
    CL_BRANCH,
    CL_LUI,
    CL_JAL,
    CL_ILL
  } cls_e;

  logic [2:0]  state;
  logic [31:0] pc;
  cls_e        cls_q;
  logic [2:0]  br_f3_q;
  logic [3:0]  tmo_cnt;
  logic        br_taken;

  // Decoder outputs (from the raw instruction bus, captured on fetch)
  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic        f3_shift;
  cls_e        d_cls;
  logic [5:0]  d_alu;
  logic [31:0] d_imm;
  logic [4:0]  d_shamt;
  logic [4:0]  d_rs1;
  logic [4:0]  d_rs2;
  logic [4:0]  d_rd;

  function automatic logic [5:0] alu_sel(input logic [2:0] fn3, input logic alt);
    logic [5:0] op;
    case (fn3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      3'b111:  op = ALU_AND;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

  // Instruction decode: classify and extract fields; illegal leaves fields at zero
  always_comb begin
    opc      = instr[6:0];
    f3       = instr[14:12];
    f7       = instr[31:25];
    f3_shift = (f3 == 3'b001) || (f3 == 3'b101);
    d_cls    = CL_ILL;
    d_alu    = ALU_ADD;
    d_imm    = '0;
    d_shamt  = '0;
    d_rs1    = '0;
    d_rs2    = '0;
    d_rd     = '0;
    case (opc)
      OP_R: begin
        if ((f3 != 3'b011) &&
            ((f7 == 7'b0000000) ||
             ((f7 == 7'b0100000) && ((f3 == 3'b000) || (f3 == 3'b101))))) begin
          d_cls = CL_ALU;
          d_alu = alu_sel(f3, f7[5]);
          d_rs1 = instr[19:15];
          d_rs2 = instr[24:20];
          d_rd  = instr[11:7];
          if (f3_shift) d_shamt = instr[24:20];
        end
      end
      OP_I: begin
        if ((f3 != 3'b011) &&
            (!f3_shift || (f7 == 7'b0000000) ||
             ((f7 == 7'b0100000) && (f3 == 3'b101)))) begin
          d_cls = CL_ALU;
          // bit 30 selects SRA only for shifts; for ADDI it is immediate data
          d_alu = alu_sel(f3, f3_shift && f7[5]);
          d_rs1 = instr[19:15];
          d_rd  = instr[11:7];
          d_imm = {{20{instr[31]}}, instr[31:20]};
          if (f3_shift) d_shamt = instr[24:20];
        end
      end
      OP_LOAD: begin
        if (f3 == 3'b010) begin
          d_cls = CL_LOAD;
          d_rs1 = instr[19:15];
          d_rd  = instr[11:7];
          d_imm = {{20{instr[31]}}, instr[31:20]};
        end
      end
      OP_STORE: begin
        if (f3 == 3'b010) begin
          d_cls = CL_STORE;
          d_rs1 = instr[19:15];
          d_rs2 = instr[24:20];
          d_imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
        end
      end
      OP_BRANCH: begin
        if ((f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b100) || (f3 == 3'b101)) begin
          d_cls = CL_BRANCH;
          d_alu = ALU_SUB;
          d_rs1 = instr[19:15];
          d_rs2 = instr[24:20];
          d_imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
        end
      end
      OP_LUI: begin
        d_cls = CL_LUI;
        d_rd  = instr[11:7];
        d_imm = {instr[31:12], 12'h000};
      end
      OP_JAL: begin
        d_cls = CL_JAL;
        d_rd  = instr[11:7];
        d_imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      end
      default: d_cls = CL_ILL;
    endcase
  end

  // Branch condition from ALU flags
  always_comb begin
    case (br_f3_q)
      3'b000:  br_taken = zero_flag;
      3'b001:  br_taken = !zero_flag;
      3'b100:  br_taken = lt_flag;
      3'b101:  br_taken = !lt_flag;
      default: br_taken = 1'b0;
    endcase
  end

  // Sequencer: state, PC, trap, captured decode fields and memory timeout
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= S_FETCH;
      pc             <= word_align(RESET_PC);
      trap           <= 1'b0;
      cls_q          <= CL_ILL;
      br_f3_q        <= '0;
      tmo_cnt        <= '0;
      read_reg_num1  <= '0;
      read_reg_num2  <= '0;
      write_reg_num1 <= '0;
      alu_control    <= '0;
      imm_val        <= '0;
      shamt          <= '0;
    end else begin
      case (state)
        S_FETCH: begin
          if (instr_valid) begin
            cls_q          <= d_cls;
            br_f3_q        <= f3;
            read_reg_num1  <= d_rs1;
            read_reg_num2  <= d_rs2;
            write_reg_num1 <= d_rd;
            alu_control    <= d_alu;
            imm_val        <= d_imm;
            shamt          <= d_shamt;
            state          <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (cls_q == CL_ILL) begin
            trap  <= 1'b1;
            state <= S_HALT;
          end else begin
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          case (cls_q)
            CL_LOAD, CL_STORE: begin
              tmo_cnt <= '0;
              state   <= S_MEM;
            end
            CL_BRANCH: begin
              pc    <= word_align(br_taken ? (pc + imm_val) : (pc + 32'd4));
              state <= S_FETCH;
            end
            default: state <= S_WB;
          endcase
        end
        S_MEM: begin
          // mem_ready wins over timeout on the last permitted cycle
          if (mem_ready) begin
            if (cls_q == CL_STORE) begin
              pc    <= word_align(pc + 32'd4);
              state <= S_FETCH;
            end else begin
              state <= S_WB;
            end
          end else if (tmo_cnt == TMO_LAST) begin
            trap  <= 1'b1;
            state <= S_HALT;
          end else begin
            tmo_cnt <= tmo_cnt + 4'd1;
          end
        end
        S_WB: begin
          pc    <= word_align((cls_q == CL_JAL) ? (pc + imm_val) : (pc + 32'd4));
          state <= S_FETCH;
        end
        S_HALT: state <= S_HALT;
        default: begin
          trap  <= 1'b1;
          state <= S_HALT;
        end
      endcase
    end
  end

  // Strobes decoded from state so reset removes them immediately
  always_comb begin
    pc_out      = pc;
    instr_req   = (state == S_FETCH);
    lb          = (state == S_MEM) && (cls_q == CL_LOAD);
    sw          = (state == S_MEM) && (cls_q == CL_STORE);
    reg_write   = (state == S_WB) && (write_reg_num1 != 5'd0);
    lui_control = (state == S_WB) && (cls_q == CL_LUI);
    jump        = (state == S_WB) && (cls_q == CL_JAL);
  end

`ifdef PERF_CNT_EN
  logic retire_evt;
  logic stall_evt;

  // Retirement and stall events
  always_comb begin
    retire_evt = (state == S_WB) ||
                 ((state == S_MEM) && mem_ready && (cls_q == CL_STORE)) ||
                 ((state == S_EXEC) && (cls_q == CL_BRANCH));
    stall_evt  = ((state == S_FETCH) && !instr_valid) ||
                 ((state == S_MEM) && !mem_ready);
  end

  // Free-running wrapping performance counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      retired_cnt <= '0;
      stall_cnt   <= '0;
    end else begin
      if (retire_evt) retired_cnt <= retired_cnt + 32'd1;
      if (stall_evt)  stall_cnt   <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Multi-cycle control FSM that sequences the RV32I-subset datapath (register file, ALU, data memory, PC).
- Fetches one instruction per pass over a valid/ready instruction port.
- Decodes the instruction and drives register numbers, ALU opcode, immediates and load/store strobes.
- Stalls on data-memory handshake.
- Owns the program counter.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
MEM_TIMEOUT, 15, max cycles waited for mem_ready before trap (4-bit counter)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-low
instr_req  out  1  request next instruction at pc_out
instr_valid  in  1  instr bus valid; sampled only while instr_req=1
instr  in  32  fetched instruction
pc_out  out  32  current PC
zero_flag  in  1  ALU result == 0
lt_flag  in  1  ALU signed less-than
mem_ready  in  1  data memory completed access
read_reg_num1  out  5  rs1
read_reg_num2  out  5  rs2
write_reg_num1  out  5  rd
reg_write  out  1  register-file write strobe, one cycle
alu_control  out  6  ALU op
imm_val  out  32  sign-extended immediate
shamt  out  5  shift amount
lb  out  1  load strobe, held until mem_ready
sw  out  1  store strobe, held until mem_ready
lui_control  out  1  write imm_val to rd
jump  out  1  JAL: write PC+4 to rd
trap  out  1  sticky illegal/timeout flag

Behaviour:
- Reset (rst=0, async):
  - state=FETCH, pc_out=RESET_PC, trap=0.
  - All strobes 0; reg numbers, alu_control, imm_val and shamt all 0.
- States: FETCH, DECODE, EXEC, MEM, WB, HALT.
- FETCH:
  - instr_req=1.
  - On instr_valid=1: latch instr into IR, go to DECODE.
  - Otherwise remain in FETCH indefinitely.
- DECODE:
  - instr_req=0; drive rs1/rs2/rd, imm_val, shamt, alu_control from IR.
  - Unknown opcode -> trap=1, go to HALT.
- EXEC: ALU settles. Next state by type:
  - Load/store -> MEM.
  - Branch -> FETCH, with PC update this edge.
  - All others -> WB.
- MEM:
  - lb or sw=1 every cycle until mem_ready=1, then LOAD->WB, STORE->FETCH (pc+=4).
  - Timeout counter starts at 0 on MEM entry and increments each cycle without mem_ready.
  - At MEM_TIMEOUT: trap=1, go to HALT, strobes drop.
- WB:
  - reg_write=1 for exactly one cycle unless rd==0, in which case reg_write=0.
  - lui_control/jump asserted alongside for LUI/JAL.
  - pc+=4, or pc+=imm for JAL. Go to FETCH.
- Branch resolution in EXEC:
  - BEQ taken iff zero_flag=1; BNE taken iff zero_flag=0.
  - BLT taken iff lt_flag=1; BGE taken iff lt_flag=0.
  - Taken: pc=pc+imm. Not taken: pc=pc+4.
- HALT: absorbing. trap stays 1, instr_req=0. Exit only via rst.
- PC arithmetic: 32-bit modulo 2^32; 0xFFFF_FFFC+4 wraps to 0. Bit[1:0] of pc_out is always 0; bit 0 of immediate is ignored.
- Latency: ALU op = 4 cycles from instr_valid sample to next instr_req. Load = 5+wait. Store = 4+wait. Branch = 3.
- alu_control encoding:
  - ADD 0, SUB 1, AND 2, OR 3, XOR 4, SLL 5, SRL 6, SRA 7, SLT 8.
  - Loads/stores/JAL/LUI use ADD; branches use SUB.
- Supported opcodes: R-type, I-type ALU, LW(lb), SW, BEQ/BNE/BLT/BGE, LUI, JAL. Everything else is illegal.
- mem_ready high outside MEM: ignored. instr_valid outside FETCH: ignored.
- Reset asserted mid-MEM: strobes drop asynchronously; no reg_write issued.

Optional Feature:
PERF_CNT_EN
- Defined: adds outputs retired_cnt[31:0] and stall_cnt[31:0], both reset to 0 and wrapping.
  - retired_cnt increments on the final cycle of each completed instruction (WB, store exit, branch exit).
  - stall_cnt increments on each FETCH cycle with instr_valid=0 and each MEM cycle with mem_ready=0.
- Undefined: ports and counters absent; FSM timing identical.

Test Plan:
- Reset mid-operation: rst low during MEM with sw=1 -> sw=0 immediately, pc_out=RESET_PC, state FETCH with instr_req=1 after release.
- ADDI x5,x0,7 (0x00700293) valid on first FETCH:
  - DECODE: read_reg_num1=0, write_reg_num1=5, imm_val=7, alu_control=0.
  - reg_write=1 exactly one cycle in WB; pc_out=4; instr_req high 4 cycles after sample.
- BEQ taken and not taken, imm=+16 at pc=8:
  - zero_flag=1 in EXEC -> pc_out=24.
  - zero_flag=0 -> pc_out=12.
  - No reg_write pulse in either case.
- LW with mem_ready delayed 3 cycles -> lb high exactly 4 cycles, reg_write pulse next cycle, pc+=4. With PERF_CNT_EN: stall_cnt=3, retired_cnt=1.
- SW with mem_ready never asserted -> sw high 15 cycles, then trap=1, HALT, instr_req stays 0 for 20+ cycles.
- Illegal opcode 0xFFFFFFFF -> trap=1 the cycle after DECODE. ADD x0,x1,x2 -> reg_write stays 0.
